fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000, meaning PC value after reset.
REQ-002 CLK  input  1  rising-edge clock, single clock domain.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 imemREN  output  1  instruction memory read request.
REQ-005 imemaddr  output  32  request address; held stable while imemREN=1 and ihit=0.
REQ-006 ihit  input  1  request complete; imemload valid this cycle.
REQ-007 imemload  input  32  instruction returned by memory.
REQ-008 stall  input  1  IF/ID latch not accepting this cycle.
REQ-009 redirect  input  1  branch/jump resolved; in-flight fetch is wrong path.
REQ-010 redirect_addr  input  32  target PC, valid when redirect=1.
REQ-011 halt  input  1  stop fetching permanently until reset.
REQ-012 ifid_wen  output  1  write enable to IF/ID latch.
REQ-013 instruction_out  output  32  instruction to IF/ID latch.
REQ-014 next_address_out  output  32  fetched PC + 4 to IF/ID latch.

Function
REQ-015 States: FETCH, HOLD, FLUSH, HALTED; registers pc, tgt, buf_instr, buf_npc.
REQ-016 imemREN=1 in FETCH and FLUSH, 0 in HOLD and HALTED; imemaddr=pc always.
REQ-017 Priority per cycle: halt > redirect > stall > normal.
REQ-018 halt=1 in any state: next state HALTED, ifid_wen=0, outstanding request abandoned.
REQ-019 FETCH, ihit=1, redirect=0, stall=0: ifid_wen=1, instruction_out=imemload, next_address_out=pc+4, pc<=pc+4; stay FETCH (one instruction per cycle on back-to-back hits).
REQ-020 FETCH, ihit=1, redirect=0, stall=1: buf_instr<=imemload, buf_npc<=pc+4, pc<=pc+4, ifid_wen=0; go HOLD.
REQ-021 FETCH, ihit=0, redirect=0: no state change, ifid_wen=0, address held.
REQ-022 FETCH, redirect=1, ihit=1: data discarded, ifid_wen=0, pc<=redirect_addr; stay FETCH.
REQ-023 FETCH, redirect=1, ihit=0: tgt<=redirect_addr, ifid_wen=0; go FLUSH (pc unchanged, request continues).
REQ-024 HOLD: instruction_out=buf_instr, next_address_out=buf_npc, ifid_wen=!stall; stall=0 -> FETCH.
REQ-025 HOLD, redirect=1: buffer dropped, ifid_wen=0 even if stall=0, pc<=redirect_addr; go FETCH.
REQ-026 FLUSH: ifid_wen=0; redirect=1 updates tgt<=redirect_addr; ihit=1 -> pc<=tgt (or redirect_addr if redirect same cycle), go FETCH.
REQ-027 HALTED: terminal; imemREN=0, ifid_wen=0, ignores all inputs except nRST.
REQ-028 When ifid_wen=0, instruction_out/next_address_out are don't-care but must not be X.
REQ-029 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no low-bit checking on redirect_addr.

Reset
REQ-030 nRST=0 asynchronously sets state FETCH, pc=PC_INIT, tgt=0, buf_instr=0, buf_npc=0.
REQ-031 During and immediately after reset: ifid_wen=0, imemREN=1, imemaddr=PC_INIT.
REQ-032 Reset mid-request or mid-HOLD/FLUSH discards all state; no write to IF/ID results.

Structure
REQ-033 fetch_state_t enum (FETCH, HOLD, FLUSH, HALTED) and word_t live in cpu_types_pkg.
REQ-034 Single module, no sub-module; one sequential block for registers, one combinational block for next-state/outputs.

Verification
REQ-035 Reset, ihit=1 for 3 cycles, stall=0 -> ifid_wen=1 three cycles, next_address_out 4, 8, 12; imemaddr 0, 4, 8.
REQ-036 ihit at pc=0x10 with stall=1 for 2 cycles -> HOLD, imemREN=0, ifid_wen=0 two cycles, then ifid_wen=1 with buf_npc=0x14; next imemaddr=0x14.
REQ-037 Redirect to 0x200 while ihit=0 at pc=0x40, ihit 2 cycles later -> no ifid_wen, FLUSH holds imemaddr=0x40, then imemaddr=0x200.
REQ-038 Redirect to 0x80 same cycle as ihit and stall=0 -> ifid_wen=0, next imemaddr=0x80.
REQ-039 halt=1 during pending request -> imemREN=0 next cycle and forever, ifid_wen stays 0 under any stimulus until nRST.
REQ-040 PC_INIT=32'hFFFF_FFFC, ihit=1 -> next_address_out=0, next imemaddr=0; nRST pulse mid-HOLD -> imemaddr=PC_INIT, ifid_wen=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word and fetch-stage state types
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FETCH, HOLD, FLUSH, HALTED} fetch_state_t;
    localparam word_t INSTR_BYTES = 32'd4;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with IF/ID backpressure buffer, redirect flush and halt
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic        ifid_wen,
    output logic [31:0] instruction_out,
    output logic [31:0] next_address_out
);
    fetch_state_t state_q, state_d;
    word_t pc_q, pc_d, tgt_q, tgt_d, buf_instr_q, buf_instr_d, buf_npc_q, buf_npc_d;
    word_t pc_inc;

    assign pc_inc = pc_q + INSTR_BYTES;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        tgt_d            = tgt_q;
        buf_instr_d      = buf_instr_q;
        buf_npc_d        = buf_npc_q;
        ifid_wen         = 1'b0;
        imemREN          = (state_q == FETCH) || (state_q == FLUSH);
        imemaddr         = pc_q;
        instruction_out  = (state_q == HOLD) ? buf_instr_q : imemload;
        next_address_out = (state_q == HOLD) ? buf_npc_q : pc_inc;
        if (halt) begin
            state_d = HALTED;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect) begin
                        pc_d    = ihit ? redirect_addr : pc_q;
                        tgt_d   = ihit ? tgt_q : redirect_addr;
                        state_d = ihit ? FETCH : FLUSH;
                    end else if (ihit) begin
                        pc_d        = pc_inc;
                        ifid_wen    = !stall;
                        buf_instr_d = stall ? imemload : buf_instr_q;
                        buf_npc_d   = stall ? pc_inc : buf_npc_q;
                        state_d     = stall ? HOLD : FETCH;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_d    = redirect_addr;
                        state_d = FETCH;
                    end else if (!stall) begin
                        ifid_wen = 1'b1;
                        state_d  = FETCH;
                    end
                end
                FLUSH: begin
                    tgt_d = redirect ? redirect_addr : tgt_q;
                    if (ihit) begin
                        pc_d    = redirect ? redirect_addr : tgt_q;
                        state_d = FETCH;
                    end
                end
                default: ;
            endcase
        end
        // The latch must never see a write while reset is asserted, even if ihit is high.
        if (!nRST) ifid_wen = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= FETCH;
            pc_q        <= PC_INIT;
            tgt_q       <= '0;
            buf_instr_q <= '0;
            buf_npc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            buf_instr_q <= buf_instr_d;
            buf_npc_q   <= buf_npc_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus with a queue-based scoreboard against a transaction-level fetch model
module tb_fetch_unit;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0, stall = 1'b0, redirect = 1'b0, halt = 1'b0;
    logic [31:0] imemload = '0, redirect_addr = '0;
    logic        imemREN, ifid_wen, imemREN2, ifid_wen2;
    logic [31:0] imemaddr, instruction_out, next_address_out;
    logic [31:0] imemaddr2, instruction_out2, next_address_out2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] q[$];
    bit          exp_ren = 1'b1;
    logic [31:0] exp_addr = '0;

    logic [31:0] m_pc = '0, m_tgt = '0, m_bi = '0, m_bn = '0;
    bit          m_wrong = 0, m_held = 0, m_halted = 0;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
        .imemload(imemload), .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
        .halt(halt), .ifid_wen(ifid_wen), .instruction_out(instruction_out),
        .next_address_out(next_address_out)
    );

    fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN2), .imemaddr(imemaddr2), .ihit(ihit),
        .imemload(imemload), .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
        .halt(halt), .ifid_wen(ifid_wen2), .instruction_out(instruction_out2),
        .next_address_out(next_address_out2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the model advances by the architectural fetch rules and
    // queues every instruction the IF/ID latch should receive this cycle.
    task automatic cyc(input bit h, input bit s, input bit r, input bit hl, input bit rst,
                       input logic [31:0] ra);
        logic [31:0] ld;
        @(posedge CLK);
        #1;
        ld = $urandom;
        nRST = rst; ihit = h & rst; stall = s; redirect = r; redirect_addr = ra; halt = hl;
        imemload = ld;
        if (!rst) begin
            m_pc = '0; m_tgt = '0; m_bi = '0; m_bn = '0;
            m_wrong = 0; m_held = 0; m_halted = 0;
        end
        exp_ren  = !m_halted && !m_held;
        exp_addr = m_pc;
        if (rst && !m_halted) begin
            if (hl) begin
                m_halted = 1;
            end else if (m_held) begin
                if (r) begin
                    m_held = 0;
                    m_pc = ra;
                end else if (!s) begin
                    q.push_back({m_bi, m_bn});
                    m_held = 0;
                end
            end else if (m_wrong) begin
                if (r) m_tgt = ra;
                if (h) begin
                    m_pc = m_tgt;
                    m_wrong = 0;
                end
            end else if (r) begin
                if (h) m_pc = ra;
                else begin
                    m_wrong = 1;
                    m_tgt = ra;
                end
            end else if (h) begin
                if (s) begin
                    m_held = 1;
                    m_bi = ld;
                    m_bn = m_pc + 32'd4;
                end else begin
                    q.push_back({ld, m_pc + 32'd4});
                end
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    always @(negedge CLK) begin
        logic [63:0] e;
        bit exp_w;
        exp_w = q.size() != 0;
        chk("imemREN", {31'b0, imemREN}, {31'b0, exp_ren});
        chk("imemaddr", imemaddr, exp_addr);
        chk("ifid_wen", {31'b0, ifid_wen}, {31'b0, exp_w});
        if (ifid_wen && exp_w) begin
            e = q.pop_front();
            chk("instruction_out", instruction_out, e[63:32]);
            chk("next_address_out", next_address_out, e[31:0]);
        end
        q.delete();
    end

    initial begin
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 1, 32'h40);
        cyc(0, 0, 1, 0, 1, 32'h200);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 1, 32'h80);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 20; i++)
            cyc($urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, 1, $urandom);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++)
            cyc(($urandom % 3) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                ($urandom % 700) == 0, ($urandom % 300) != 0, $urandom);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        @(negedge CLK);
        chk("wrap_reset_addr", imemaddr2, 32'hFFFF_FFFC);
        chk("wrap_reset_wen", {31'b0, ifid_wen2}, 32'd0);
        cyc(1, 0, 0, 0, 1, 0);
        @(negedge CLK);
        chk("wrap_wen", {31'b0, ifid_wen2}, 32'd1);
        chk("wrap_npc", next_address_out2, 32'h0);
        cyc(1, 1, 0, 0, 1, 0);
        @(negedge CLK);
        chk("wrap_addr_after", imemaddr2, 32'h0);
        cyc(0, 1, 0, 0, 1, 0);
        @(negedge CLK);
        chk("wrap_hold_ren", {31'b0, imemREN2}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("wrap_midhold_rst_addr", imemaddr2, 32'hFFFF_FFFC);
        chk("wrap_midhold_rst_wen", {31'b0, ifid_wen2}, 32'd0);
        chk("wrap_midhold_rst_ren", {31'b0, imemREN2}, 32'd1);
        cyc(0, 0, 0, 0, 1, 0);
        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
